regfile_wr_sched: RTL and testbench

Write-port scheduler for the multi-ported load-initialised register file. It shares the file's single write port (WE, ADDR_IN, D_IN) among NREQ requesters using round-robin arbitration with a valid/ready handshake. It also contains a clear sequencer that zero-fills the address range LO..HI on command. It sits between the core's writeback sources and the register file; the read ports are not touched.

---
 rtl/regfile_wr_sched_if.sv | 26 ++
 rtl/regfile_wr_sched.sv | 100 ++++++++++
 tb/tb_regfile_wr_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/regfile_wr_sched_if.sv
// regfile_wr_sched_if: requester handshake, clear control and register-file write port bundle
interface regfile_wr_sched_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREQ   = 4
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   clr_start;
  logic                   clr_busy;
  logic                   clr_done;
  logic                   oob_err;
  logic                   we;
  logic [ADDR_W-1:0]      addr_in;
  logic [DATA_W-1:0]      d_in;
  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, clr_done, oob_err, we, addr_in, d_in
  );
  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, clr_done, oob_err, we, addr_in, d_in
  );
endinterface

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: round-robin write-port scheduler; zero-fill clear built with REGFILE_WR_SCHED_CLEAR_EN
module regfile_wr_sched #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREQ   = 4,
  parameter int LO     = 0,
  parameter int HI     = 31
) (
  input logic               clk,
  input logic               rst,
  regfile_wr_sched_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0]     rr_ptr, gnt_idx;
  logic              gnt_any, arb_en, xfer, g_oob;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  // Scan from the highest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[PW'((int'(rr_ptr) + i) % NREQ)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end
  assign g_addr = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign g_data = bus.req_data[gnt_idx*DATA_W +: DATA_W];
  assign g_oob  = int'(g_addr) < LO || int'(g_addr) > HI;
  assign bus.req_ready = (arb_en && gnt_any) ? NREQ'(1) << gnt_idx : '0;
  assign xfer = |bus.req_ready;
`ifdef REGFILE_WR_SCHED_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  assign arb_en = !rst && state == IDLE && !bus.clr_start;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      clr_addr     <= '0;
      bus.clr_busy <= 1'b0;
      bus.clr_done <= 1'b0;
      rr_ptr       <= '0;
      bus.we       <= 1'b0;
      bus.addr_in  <= '0;
      bus.d_in     <= '0;
      bus.oob_err  <= 1'b0;
    end else begin
      bus.clr_done <= 1'b0;
      bus.we       <= xfer && !g_oob;
      bus.oob_err  <= xfer && g_oob;
      if (xfer) rr_ptr <= gnt_idx == PW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
      if (xfer && !g_oob) begin
        bus.addr_in <= g_addr;
        bus.d_in    <= g_data;
      end
      if (state == CLEAR) begin
        bus.we      <= 1'b1;
        bus.addr_in <= clr_addr;
        bus.d_in    <= '0;
        clr_addr    <= clr_addr + 1'b1;
        if (clr_addr == ADDR_W'(HI)) begin
          state        <= IDLE;
          bus.clr_busy <= 1'b0;
          bus.clr_done <= 1'b1;
        end
      end else if (bus.clr_start) begin
        state        <= CLEAR;
        bus.clr_busy <= 1'b1;
        clr_addr     <= ADDR_W'(LO);
      end
    end
  end
`else
  logic unused_clr_start;
  assign unused_clr_start = bus.clr_start;
  assign arb_en       = !rst;
  assign bus.clr_busy = 1'b0;
  assign bus.clr_done = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      bus.we      <= 1'b0;
      bus.addr_in <= '0;
      bus.d_in    <= '0;
      bus.oob_err <= 1'b0;
    end else begin
      bus.we      <= xfer && !g_oob;
      bus.oob_err <= xfer && g_oob;
      if (xfer) rr_ptr <= gnt_idx == PW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
      if (xfer && !g_oob) begin
        bus.addr_in <= g_addr;
        bus.d_in    <= g_data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed checks of arbitration, out-of-range handling, clear and reset
module tb_regfile_wr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  regfile_wr_sched_if #(.ADDR_W(5), .DATA_W(32), .NREQ(4)) b1 ();
  regfile_wr_sched_if #(.ADDR_W(5), .DATA_W(32), .NREQ(4)) b2 ();
  regfile_wr_sched #(.ADDR_W(5), .DATA_W(32), .NREQ(4), .LO(0), .HI(31))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  regfile_wr_sched #(.ADDR_W(5), .DATA_W(32), .NREQ(4), .LO(0), .HI(15))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    b1.req_valid = 4'b1111;
    b1.clr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b1.req_addr[i*5 +: 5]   = 5'(i + 1);
      b1.req_data[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    b2.req_valid = '0;
    b2.req_addr  = '0;
    b2.req_data  = '0;
    b2.clr_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", b1.req_ready, 0);
      chk("rst_we", b1.we, 0);
      chk("rst_addr", b1.addr_in, 0);
      chk("rst_busy", b1.clr_busy, 0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_ready", b1.req_ready, 64'(1) << (c % 4));
      chk("rr_we", b1.we, c > 0);
      if (c > 0) begin
        chk("rr_addr", b1.addr_in, (c - 1) % 4 + 1);
        chk("rr_data", b1.d_in, 32'hA0 + (c - 1) % 4);
      end
      step();
    end
    b1.req_valid = 4'b1010;
    @(negedge clk);
    chk("sparse_g3a", b1.req_ready, 4'b1000);
    step();
    @(negedge clk);
    chk("sparse_g1", b1.req_ready, 4'b0010);
    chk("sparse_addr3", b1.addr_in, 4);
    chk("sparse_data3", b1.d_in, 32'hA3);
    step();
    @(negedge clk);
    chk("sparse_g3b", b1.req_ready, 4'b1000);
    chk("sparse_addr1", b1.addr_in, 2);
    step();
    b1.req_valid = 4'b0000;
    @(negedge clk);
    chk("sparse_idle_ready", b1.req_ready, 0);
    chk("sparse_last_addr", b1.addr_in, 4);
    step();
    b2.req_valid = 4'b0100;
    b2.req_addr[10 +: 5]  = 5'd20;
    b2.req_data[64 +: 32] = 32'h55;
    @(negedge clk);
    chk("oob_ready", b2.req_ready, 4'b0100);
    step();
    b2.req_valid = 4'b1111;
    b2.req_addr[15 +: 5]  = 5'd3;
    b2.req_data[96 +: 32] = 32'h33;
    @(negedge clk);
    chk("oob_we", b2.we, 0);
    chk("oob_err", b2.oob_err, 1);
    chk("oob_addr_hold", b2.addr_in, 0);
    chk("oob_ptr3", b2.req_ready, 4'b1000);
    step();
    b2.req_valid = 4'b0000;
    @(negedge clk);
    chk("oob_next_we", b2.we, 1);
    chk("oob_next_addr", b2.addr_in, 3);
    chk("oob_next_data", b2.d_in, 32'h33);
    chk("oob_err_clr", b2.oob_err, 0);
    step();
    b1.req_valid = 4'b1111;
    b1.clr_start = 1'b1;
`ifdef REGFILE_WR_SCHED_CLEAR_EN
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (k <= 33) chk("clr_ready", b1.req_ready, k <= 32 ? 0 : 1);
      if (k >= 1) chk("clr_we", b1.we, k >= 2);
      if (k >= 2) begin
        chk("clr_addr", b1.addr_in, k <= 33 ? k - 2 : 1);
        chk("clr_data", b1.d_in, k <= 33 ? 0 : 32'hA0);
      end
      chk("clr_busy", b1.clr_busy, k >= 1 && k <= 32);
      chk("clr_done", b1.clr_done, k == 33);
      step();
      b1.clr_start = 1'b0;
    end
`else
    @(negedge clk);
    chk("noclr_ready", b1.req_ready, 4'b0001);
    step();
    b1.clr_start = 1'b0;
    @(negedge clk);
    chk("noclr_busy", b1.clr_busy, 0);
    chk("noclr_done", b1.clr_done, 0);
    chk("noclr_we", b1.we, 1);
    chk("noclr_addr", b1.addr_in, 1);
    step();
`endif
    b1.req_valid = 4'b0000;
    b1.clr_start = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      b1.clr_start = 1'b0;
    end
    rst = 1'b1;
`ifdef REGFILE_WR_SCHED_CLEAR_EN
    @(negedge clk);
    chk("mid_we_before", b1.we, 1);
    chk("mid_addr_before", b1.addr_in, 9);
`endif
    step();
    rst = 1'b0;
    b1.req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_we", b1.we, 0);
    chk("mid_busy", b1.clr_busy, 0);
    chk("mid_ready", b1.req_ready, 4'b0100);
    step();
    b1.req_valid = 4'b0000;
    @(negedge clk);
    chk("mid_post_we", b1.we, 1);
    chk("mid_post_addr", b1.addr_in, 3);
    for (int k = 0; k < 25; k++) begin
      if (b1.clr_done !== 1'b0 || b1.clr_busy !== 1'b0) chk("mid_no_done", {b1.clr_busy, b1.clr_done}, 0);
      step();
      @(negedge clk);
    end
    chk("mid_final_done", b1.clr_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
